commit_lockstep_checker: RTL and testbench
==========================================

Name: commit_lockstep_checker

Overview:
Synthesizable lockstep checker that consumes two commit streams: one from the CPU core's debug commit port and one from the golden RV32I model. It buffers each stream in its own FIFO, so the two sources may commit with different latencies. When both FIFO heads are present, it pops them together and compares them field by field. It reports a sticky PASS or FAIL with an error code, the failing PC and a commit count. It replaces the negedge comparison in simulation and is required for pipelined cores, where commit timing differs from the golden model.

Parameters:
DEPTH, 4, entries per commit FIFO; must be a power of two ≥2.
MAX_CYCLES, 20000, RUN-state cycle limit before timeout failure.
DONE_ADDR, 32'h0000_0100, completion store address.
DONE_DATA, 32'h0000_0001, completion store data.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
enable  in  1  starts checking; sampled only in IDLE.
d_valid  in  1  DUT commit valid.
d_pc, d_instr, d_wdata, d_memaddr, d_memwdata  in  32 each  DUT commit fields.
d_regwrite, d_memwrite  in  1 each  DUT commit flags.
d_rd  in  5  DUT destination register.
d_ready  out  1  DUT FIFO can accept.
g_valid, g_pc, g_instr, g_regwrite, g_rd, g_wdata, g_memwrite, g_memaddr, g_memwdata  in  same widths  golden commit bundle.
g_ready  out  1  golden FIFO can accept.
pass  out  1  sticky test-passed flag.
fail  out  1  sticky test-failed flag.
err_code  out  4  failure cause.
err_pc  out  32  DUT PC of the failing pair (0 for codes 8 and 9).
err_dut_val  out  32  DUT value of the failing field (flags zero-extended).
err_gold_val  out  32  golden value of the failing field (flags zero-extended).
commit_count  out  32  number of pairs compared and matched.

Behaviour:
- Reset values: all outputs 0; state = IDLE; FIFOs empty; cycle counter 0.
- States and transitions:
  - IDLE → RUN when enable = 1.
  - RUN → PASS or FAIL.
  - PASS and FAIL are terminal until reset.
  - enable is ignored outside IDLE.
- Ready signals:
  - d_ready = (state == RUN) && !d_full; g_ready is the same for the golden FIFO.
  - In IDLE and in the terminal states, ready = 0 and valid is ignored.
- FIFO behaviour:
  - A push occurs on valid && ready.
  - Pointers wrap modulo DEPTH; full and empty use an extra pointer bit.
  - A simultaneous push and pop on a non-full FIFO is legal; occupancy is unchanged.
- Compare:
  - In RUN, when both FIFOs are non-empty, both heads are popped in the same cycle.
  - The comparison is combinational on the heads; the result is registered.
  - pass, fail and error outputs assert 1 cycle after the pop.
- Field check priority (lowest code wins):
  - 1 pc mismatch.
  - 2 regwrite flag mismatch, checked only if either flag is set.
  - 3 rd mismatch and 4 wdata mismatch, checked only if d_regwrite.
  - 5 memwrite flag mismatch, checked only if either flag is set.
  - 6 memaddr mismatch and 7 memwdata mismatch, checked only if d_memwrite.
- Completion:
  - A matching pair with d_memwrite, d_memaddr == DONE_ADDR and d_memwdata == DONE_DATA → PASS.
  - A mismatch in the same pair takes precedence (FAIL).
  - commit_count increments for every matching pair, including the completion pair.
- Timeout:
  - The cycle counter increments each RUN cycle, saturating.
  - When it reaches MAX_CYCLES with no PASS or FAIL → FAIL, err_code 8.
- Overflow: in RUN, (d_valid && !d_ready) || (g_valid && !g_ready) → FAIL, err_code 9. A dropped commit is fatal.
- Simultaneous events in one cycle: compare result beats overflow, and overflow beats timeout.
- Terminal states:
  - FIFOs are frozen and no further pops occur.
  - All outputs hold.
- Reset mid-operation: outputs clear immediately (asynchronously); the checker returns to IDLE with empty FIFOs.
- pass and fail are never both 1.

Test Plan:
- Identical streams, DUT 0 cycles and golden 3 cycles late:
  - Stimulus: 10 commits; the 10th stores 0x1 to 0x100.
  - Response: pass = 1 one cycle after the 10th pop; commit_count = 10; fail = 0.
- Matching pcs, but DUT wdata 0x5 vs golden 0x6 on rd = x3 at pc 0x8:
  - Response: fail = 1, err_code = 4, err_pc = 0x8, err_dut_val = 5, err_gold_val = 6.
- Pair with both a pc mismatch (0x10 vs 0x14) and a wdata mismatch:
  - Response: err_code = 1 (priority), err_dut_val = 0x10.
- Golden source stalled while the DUT pushes DEPTH+1 = 5 commits back-to-back:
  - Response: d_ready = 0 after the 4th push; the 5th valid triggers fail with err_code 9.
- MAX_CYCLES = 50, enable = 1, no commits:
  - Response: fail = 1 with err_code 8 after exactly 50 RUN cycles.
- Reset asserted mid-run with 2 entries buffered:
  - Response: all outputs 0 without waiting for a clock edge; after release, checker is in IDLE with d_ready = 0 until enable.

Source files
------------

// File: rtl/commit_lockstep_checker.sv
// commit_lockstep_checker
//
// Lockstep checker for two commit streams: the CPU core's debug commit port
// (d_*) and a golden RV32I model (g_*). Each stream is buffered in its own
// FIFO, so the two sources may commit with different latencies. Whenever both
// FIFO heads are present they are popped together and compared field by
// field. The outcome is reported as a sticky pass or fail flag, together with
// an error code, the failing PC and the number of matched pairs.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              starts checking (sampled only in IDLE)
//   d_* / g_*           commit bundles (valid, pc, instr, regwrite, rd, wdata,
//                       memwrite, memaddr, memwdata) for DUT and golden model
//   d_ready / g_ready   FIFO can accept a commit (RUN and not full)
//   pass / fail         sticky result flags, never both set
//   err_code            1 pc, 2 regwrite, 3 rd, 4 wdata, 5 memwrite,
//                       6 memaddr, 7 memwdata, 8 timeout, 9 dropped commit
//   err_pc              DUT PC of the failing pair (0 for codes 8 and 9)
//   err_dut_val         DUT value of the failing field (flags zero-extended)
//   err_gold_val        golden value of the failing field
//   commit_count        number of pairs compared and matched
//
// state | meaning
// IDLE  | waiting for enable; FIFOs closed
// RUN   | accepting commits, comparing pairs, counting cycles
// PASS  | completion store seen in a matching pair; frozen until reset
// FAIL  | mismatch, timeout or dropped commit; frozen until reset

module commit_lockstep_checker #(
  parameter int          DEPTH      = 4,
  parameter int          MAX_CYCLES = 20000,
  parameter logic [31:0] DONE_ADDR  = 32'h0000_0100,
  parameter logic [31:0] DONE_DATA  = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,

  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic        d_regwrite,
  input  logic [4:0]  d_rd,
  input  logic [31:0] d_wdata,
  input  logic        d_memwrite,
  input  logic [31:0] d_memaddr,
  input  logic [31:0] d_memwdata,
  output logic        d_ready,

  input  logic        g_valid,
  input  logic [31:0] g_pc,
  input  logic [31:0] g_instr,
  input  logic        g_regwrite,
  input  logic [4:0]  g_rd,
  input  logic [31:0] g_wdata,
  input  logic        g_memwrite,
  input  logic [31:0] g_memaddr,
  input  logic [31:0] g_memwdata,
  output logic        g_ready,

  output logic        pass,
  output logic        fail,
  output logic [3:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_dut_val,
  output logic [31:0] err_gold_val,
  output logic [31:0] commit_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  // instr is carried by both ports but is not one of the compared fields,
  // so it is not buffered.
  typedef struct packed {
    logic [31:0] pc;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwdata;
  } commit_t;

  state_t      state;
  logic [31:0] cycle_cnt;

  commit_t     d_mem [DEPTH];
  commit_t     g_mem [DEPTH];
  logic [AW:0] d_wptr, d_rptr, g_wptr, g_rptr;
  logic        d_full, d_empty, g_full, g_empty;
  logic        d_push, g_push, pop;
  logic        running;
  commit_t     d_in, g_in, d_head, g_head;

  logic [3:0]  cmp_code;
  logic [31:0] cmp_dut, cmp_gold;
  logic        cmp_done;
  logic        overflow, timeout;

  logic        unused_instr;
  assign unused_instr = ^{d_instr, g_instr};

  assign running = (state == S_RUN);

  assign d_in = '{pc: d_pc, regwrite: d_regwrite, rd: d_rd, wdata: d_wdata,
                  memwrite: d_memwrite, memaddr: d_memaddr, memwdata: d_memwdata};
  assign g_in = '{pc: g_pc, regwrite: g_regwrite, rd: g_rd, wdata: g_wdata,
                  memwrite: g_memwrite, memaddr: g_memaddr, memwdata: g_memwdata};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign d_empty = (d_wptr == d_rptr);
  assign g_empty = (g_wptr == g_rptr);
  assign d_full  = (d_wptr[AW] != d_rptr[AW]) && (d_wptr[AW-1:0] == d_rptr[AW-1:0]);
  assign g_full  = (g_wptr[AW] != g_rptr[AW]) && (g_wptr[AW-1:0] == g_rptr[AW-1:0]);

  assign d_ready = running && !d_full;
  assign g_ready = running && !g_full;
  assign d_push  = d_valid && d_ready;
  assign g_push  = g_valid && g_ready;
  assign pop     = running && !d_empty && !g_empty;

  assign d_head = d_mem[d_rptr[AW-1:0]];
  assign g_head = g_mem[g_rptr[AW-1:0]];

  // Ready is based on occupancy before any same-cycle pop, so a source that
  // presents valid against a full FIFO is flagged even if a pop happens.
  assign overflow = (d_valid && !d_ready) || (g_valid && !g_ready);
  assign timeout  = (cycle_cnt == 32'(MAX_CYCLES - 1));

  always_comb begin
    cmp_code = 4'd0;
    cmp_dut  = 32'd0;
    cmp_gold = 32'd0;
    if (d_head.pc != g_head.pc) begin
      cmp_code = 4'd1;
      cmp_dut  = d_head.pc;
      cmp_gold = g_head.pc;
    end else if (d_head.regwrite != g_head.regwrite) begin
      cmp_code = 4'd2;
      cmp_dut  = {31'd0, d_head.regwrite};
      cmp_gold = {31'd0, g_head.regwrite};
    end else if (d_head.regwrite && (d_head.rd != g_head.rd)) begin
      cmp_code = 4'd3;
      cmp_dut  = {27'd0, d_head.rd};
      cmp_gold = {27'd0, g_head.rd};
    end else if (d_head.regwrite && (d_head.wdata != g_head.wdata)) begin
      cmp_code = 4'd4;
      cmp_dut  = d_head.wdata;
      cmp_gold = g_head.wdata;
    end else if (d_head.memwrite != g_head.memwrite) begin
      cmp_code = 4'd5;
      cmp_dut  = {31'd0, d_head.memwrite};
      cmp_gold = {31'd0, g_head.memwrite};
    end else if (d_head.memwrite && (d_head.memaddr != g_head.memaddr)) begin
      cmp_code = 4'd6;
      cmp_dut  = d_head.memaddr;
      cmp_gold = g_head.memaddr;
    end else if (d_head.memwrite && (d_head.memwdata != g_head.memwdata)) begin
      cmp_code = 4'd7;
      cmp_dut  = d_head.memwdata;
      cmp_gold = g_head.memwdata;
    end
  end

  assign cmp_done = d_head.memwrite && (d_head.memaddr == DONE_ADDR) &&
                    (d_head.memwdata == DONE_DATA);

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (d_push) d_mem[d_wptr[AW-1:0]] <= d_in;
    if (g_push) g_mem[g_wptr[AW-1:0]] <= g_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_wptr <= '0;
      d_rptr <= '0;
      g_wptr <= '0;
      g_rptr <= '0;
    end else begin
      if (d_push) d_wptr <= d_wptr + 1'b1;
      if (g_push) g_wptr <= g_wptr + 1'b1;
      if (pop) begin
        d_rptr <= d_rptr + 1'b1;
        g_rptr <= g_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cycle_cnt    <= 32'd0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_code     <= 4'd0;
      err_pc       <= 32'd0;
      err_dut_val  <= 32'd0;
      err_gold_val <= 32'd0;
      commit_count <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_RUN;
        end
        S_RUN: begin
          if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
          if (pop && (cmp_code == 4'd0)) commit_count <= commit_count + 32'd1;
          // Priority: compare result, then dropped commit, then timeout.
          if (pop && (cmp_code != 4'd0)) begin
            state        <= S_FAIL;
            fail         <= 1'b1;
            err_code     <= cmp_code;
            err_pc       <= d_head.pc;
            err_dut_val  <= cmp_dut;
            err_gold_val <= cmp_gold;
          end else if (pop && cmp_done) begin
            state <= S_PASS;
            pass  <= 1'b1;
          end else if (overflow) begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            err_code <= 4'd9;
          end else if (timeout) begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            err_code <= 4'd8;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_lockstep_checker.sv
module tb_commit_lockstep_checker;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic        d_valid, d_regwrite, d_memwrite, d_ready;
  logic [31:0] d_pc, d_instr, d_wdata, d_memaddr, d_memwdata;
  logic [4:0]  d_rd;
  logic        g_valid, g_regwrite, g_memwrite, g_ready;
  logic [31:0] g_pc, g_instr, g_wdata, g_memaddr, g_memwdata;
  logic [4:0]  g_rd;
  logic        pass, fail;
  logic [3:0]  err_code;
  logic [31:0] err_pc, err_dut_val, err_gold_val, commit_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  commit_lockstep_checker #(
    .DEPTH(4), .MAX_CYCLES(50), .DONE_ADDR(32'h100), .DONE_DATA(32'h1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_regwrite(d_regwrite),
    .d_rd(d_rd), .d_wdata(d_wdata), .d_memwrite(d_memwrite),
    .d_memaddr(d_memaddr), .d_memwdata(d_memwdata), .d_ready(d_ready),
    .g_valid(g_valid), .g_pc(g_pc), .g_instr(g_instr), .g_regwrite(g_regwrite),
    .g_rd(g_rd), .g_wdata(g_wdata), .g_memwrite(g_memwrite),
    .g_memaddr(g_memaddr), .g_memwdata(g_memwdata), .g_ready(g_ready),
    .pass(pass), .fail(fail), .err_code(err_code), .err_pc(err_pc),
    .err_dut_val(err_dut_val), .err_gold_val(err_gold_val),
    .commit_count(commit_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [31:0] pc, input logic rw,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic mw, input logic [31:0] ma, input logic [31:0] md);
    d_valid = v; d_pc = pc; d_instr = pc ^ 32'h13; d_regwrite = rw; d_rd = rd;
    d_wdata = wd; d_memwrite = mw; d_memaddr = ma; d_memwdata = md;
  endtask

  task automatic drive_g(input logic v, input logic [31:0] pc, input logic rw,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic mw, input logic [31:0] ma, input logic [31:0] md);
    g_valid = v; g_pc = pc; g_instr = pc ^ 32'h13; g_regwrite = rw; g_rd = rd;
    g_wdata = wd; g_memwrite = mw; g_memaddr = ma; g_memwdata = md;
  endtask

  // Stream commit i: register writes, except commit 9 which is the
  // completion store of 0x1 to 0x100.
  task automatic drive_stream(input bit golden, input logic v, input int i);
    logic [31:0] pc, wd, ma, md;
    logic        rw, mw;
    logic [4:0]  rd;
    pc = 32'(i * 4);
    rw = (i != 9);
    rd = 5'(i + 1);
    wd = 32'(i * 17);
    mw = (i == 9);
    ma = mw ? 32'h100 : 32'h0;
    md = mw ? 32'h1 : 32'h0;
    if (golden) drive_g(v, pc, rw, rd, wd, mw, ma, md);
    else        drive_d(v, pc, rw, rd, wd, mw, ma, md);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    drive_d(1'b0, 0, 0, 0, 0, 0, 0, 0);
    drive_g(1'b0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic start_run();
    do_reset();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if ({pass, fail} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b want 00", {pass, fail}); end
    compared++; if (err_code !== 4'd0 || err_pc !== 32'd0) begin mismatched++; $display("FAIL reset_err: got code %0d pc %h want 0 0", err_code, err_pc); end
    compared++; if (commit_count !== 32'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", commit_count); end
    // Valid in IDLE must be ignored: no ready, no overflow failure.
    d_valid = 1'b1; g_valid = 1'b1;
    tick();
    compared++; if ({d_ready, g_ready} !== 2'b00) begin mismatched++; $display("FAIL idle_ready: got %b want 00", {d_ready, g_ready}); end
    tick();
    compared++; if (fail !== 1'b0) begin mismatched++; $display("FAIL idle_valid_ignored: got fail %b want 0", fail); end
    d_valid = 1'b0; g_valid = 1'b0;
  endtask

  // DUT commits every other cycle, golden lags by 3 cycles.
  task automatic test_pass_stream();
    start_run();
    for (int c = 0; c < 22; c++) begin
      drive_stream(1'b0, (c % 2 == 0) && (c < 20), c / 2);
      drive_stream(1'b1, (c >= 3) && (c % 2 == 1), (c - 3) / 2);
      tick();
    end
    d_valid = 1'b0; g_valid = 1'b0;
    compared++; if (pass !== 1'b0 || commit_count !== 32'd9) begin mismatched++; $display("FAIL stream_before_last: got pass %b count %0d want 0 9", pass, commit_count); end
    tick();
    compared++; if (pass !== 1'b1 || fail !== 1'b0) begin mismatched++; $display("FAIL stream_pass: got pass %b fail %b want 1 0", pass, fail); end
    compared++; if (commit_count !== 32'd10) begin mismatched++; $display("FAIL stream_count: got %0d want 10", commit_count); end
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    compared++; if (pass !== 1'b1 || commit_count !== 32'd10 || d_ready !== 1'b0) begin mismatched++; $display("FAIL pass_hold: got pass %b count %0d ready %b want 1 10 0", pass, commit_count, d_ready); end
  endtask

  task automatic test_wdata_mismatch();
    start_run();
    drive_d(1'b1, 32'h4, 1'b1, 5'd2, 32'h9, 1'b0, 0, 0);
    drive_g(1'b1, 32'h4, 1'b1, 5'd2, 32'h9, 1'b0, 0, 0);
    tick();
    drive_d(1'b1, 32'h8, 1'b1, 5'd3, 32'h5, 1'b0, 0, 0);
    drive_g(1'b1, 32'h8, 1'b1, 5'd3, 32'h6, 1'b0, 0, 0);
    tick();
    d_valid = 1'b0; g_valid = 1'b0;
    compared++; if (fail !== 1'b0 || commit_count !== 32'd1) begin mismatched++; $display("FAIL wdata_first_pair: got fail %b count %0d want 0 1", fail, commit_count); end
    tick();
    compared++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 4'd4) begin mismatched++; $display("FAIL wdata_code: got fail %b pass %b code %0d want 1 0 4", fail, pass, err_code); end
    compared++; if (err_pc !== 32'h8 || err_dut_val !== 32'd5 || err_gold_val !== 32'd6) begin mismatched++; $display("FAIL wdata_vals: got pc %h dut %h gold %h want 8 5 6", err_pc, err_dut_val, err_gold_val); end
    compared++; if (commit_count !== 32'd1) begin mismatched++; $display("FAIL wdata_count: got %0d want 1", commit_count); end
  endtask

  task automatic test_field_priority();
    logic [3:0]  exp_code;
    logic [31:0] exp_dv, exp_gv, exp_pc;
    for (int k = 0; k < 7; k++) begin
      start_run();
      case (k)
        0: begin // pc and wdata both differ: pc wins
          drive_d(1'b1, 32'h10, 1'b1, 5'd3, 32'h1, 1'b0, 0, 0);
          drive_g(1'b1, 32'h14, 1'b1, 5'd3, 32'h2, 1'b0, 0, 0);
          exp_code = 4'd1; exp_dv = 32'h10; exp_gv = 32'h14;
        end
        1: begin
          drive_d(1'b1, 32'h20, 1'b0, 5'd3, 32'h1, 1'b0, 0, 0);
          drive_g(1'b1, 32'h20, 1'b1, 5'd3, 32'h1, 1'b0, 0, 0);
          exp_code = 4'd2; exp_dv = 32'd0; exp_gv = 32'd1;
        end
        2: begin // rd and wdata differ: rd wins
          drive_d(1'b1, 32'h24, 1'b1, 5'd3, 32'h7, 1'b0, 0, 0);
          drive_g(1'b1, 32'h24, 1'b1, 5'd4, 32'h8, 1'b0, 0, 0);
          exp_code = 4'd3; exp_dv = 32'd3; exp_gv = 32'd4;
        end
        3: begin
          drive_d(1'b1, 32'h28, 1'b0, 5'd0, 32'h0, 1'b0, 32'h200, 32'h5);
          drive_g(1'b1, 32'h28, 1'b0, 5'd0, 32'h0, 1'b1, 32'h200, 32'h5);
          exp_code = 4'd5; exp_dv = 32'd0; exp_gv = 32'd1;
        end
        4: begin
          drive_d(1'b1, 32'h2c, 1'b0, 5'd0, 32'h0, 1'b1, 32'h200, 32'h5);
          drive_g(1'b1, 32'h2c, 1'b0, 5'd0, 32'h0, 1'b1, 32'h204, 32'h6);
          exp_code = 4'd6; exp_dv = 32'h200; exp_gv = 32'h204;
        end
        5: begin // completion store with wrong golden data must fail
          drive_d(1'b1, 32'h30, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h1);
          drive_g(1'b1, 32'h30, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h2);
          exp_code = 4'd7; exp_dv = 32'h1; exp_gv = 32'h2;
        end
        default: begin // wdata ignored when neither side writes a register
          drive_d(1'b1, 32'h34, 1'b0, 5'd1, 32'h11, 1'b0, 0, 0);
          drive_g(1'b1, 32'h34, 1'b0, 5'd2, 32'h22, 1'b0, 0, 0);
          exp_code = 4'd0; exp_dv = 32'd0; exp_gv = 32'd0;
        end
      endcase
      exp_pc = (exp_code != 4'd0) ? d_pc : 32'd0;
      tick();
      d_valid = 1'b0; g_valid = 1'b0;
      tick();
      compared++; if (fail !== (exp_code != 4'd0) || pass !== 1'b0 || err_code !== exp_code) begin mismatched++; $display("FAIL prio_code[%0d]: got fail %b pass %b code %0d want code %0d", k, fail, pass, err_code, exp_code); end
      compared++; if (err_pc !== exp_pc || err_dut_val !== exp_dv || err_gold_val !== exp_gv) begin mismatched++; $display("FAIL prio_vals[%0d]: got pc %h dut %h gold %h want %h %h %h", k, err_pc, err_dut_val, err_gold_val, exp_pc, exp_dv, exp_gv); end
    end
  endtask

  task automatic test_overflow();
    start_run();
    for (int i = 0; i < 4; i++) begin
      compared++; if (d_ready !== 1'b1) begin mismatched++; $display("FAIL ovf_ready[%0d]: got %b want 1", i, d_ready); end
      drive_stream(1'b0, 1'b1, i);
      tick();
    end
    compared++; if (d_ready !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL ovf_full: got ready %b fail %b want 0 0", d_ready, fail); end
    drive_stream(1'b0, 1'b1, 4);
    tick();
    d_valid = 1'b0;
    compared++; if (fail !== 1'b1 || err_code !== 4'd9 || err_pc !== 32'd0) begin mismatched++; $display("FAIL ovf_code: got fail %b code %0d pc %h want 1 9 0", fail, err_code, err_pc); end
    compared++; if ({d_ready, g_ready} !== 2'b00) begin mismatched++; $display("FAIL ovf_frozen: got %b want 00", {d_ready, g_ready}); end
  endtask

  task automatic test_timeout();
    start_run();
    repeat (49) tick();
    compared++; if (fail !== 1'b0) begin mismatched++; $display("FAIL timeout_early: got fail %b want 0", fail); end
    tick();
    compared++; if (fail !== 1'b1 || err_code !== 4'd8 || pass !== 1'b0) begin mismatched++; $display("FAIL timeout_code: got fail %b code %0d pass %b want 1 8 0", fail, err_code, pass); end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    drive_d(1'b1, 32'h4, 1'b1, 5'd1, 32'h1, 1'b0, 0, 0);
    drive_g(1'b1, 32'h4, 1'b1, 5'd1, 32'h1, 1'b0, 0, 0);
    tick();
    g_valid = 1'b0;
    drive_d(1'b1, 32'h8, 1'b1, 5'd1, 32'h2, 1'b0, 0, 0);
    tick();
    drive_d(1'b1, 32'hc, 1'b1, 5'd1, 32'h3, 1'b0, 0, 0);
    tick();
    d_valid = 1'b0;
    compared++; if (commit_count !== 32'd1) begin mismatched++; $display("FAIL midrst_pre: got count %0d want 1", commit_count); end
    #2 reset = 1'b1;
    #1;
    compared++; if (commit_count !== 32'd0 || d_ready !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL midrst_async: got count %0d ready %b pass %b fail %b want 0 0 0 0", commit_count, d_ready, pass, fail); end
    #1 reset = 1'b0;
    tick();
    compared++; if (d_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_idle: got ready %b want 0", d_ready); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    compared++; if (d_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_run: got ready %b want 1", d_ready); end
    // A stale DUT entry would pair with this golden commit and mismatch.
    drive_d(1'b1, 32'h40, 1'b1, 5'd2, 32'h77, 1'b0, 0, 0);
    drive_g(1'b1, 32'h40, 1'b1, 5'd2, 32'h77, 1'b0, 0, 0);
    tick();
    d_valid = 1'b0; g_valid = 1'b0;
    tick();
    compared++; if (fail !== 1'b0 || commit_count !== 32'd1) begin mismatched++; $display("FAIL midrst_empty: got fail %b count %0d want 0 1", fail, commit_count); end
  endtask

  initial begin
    test_reset();
    test_pass_stream();
    test_wdata_mismatch();
    test_field_priority();
    test_overflow();
    test_timeout();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
